// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master drives request and grantReady; slave (the arbiter) returns the registered grant.
interface round_robin_arbiter_if #(
  parameter int REQUESTERS = 8
);
  logic [REQUESTERS-1:0] request;
  logic                  grantReady;
  logic                  grantValid;
  logic [REQUESTERS-1:0] grantOneHot;

  modport master (
    output request,
    output grantReady,
    input  grantValid,
    input  grantOneHot
  );

  modport slave (
    input  request,
    input  grantReady,
    output grantValid,
    output grantOneHot
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until downstream accepts it.
//   state      | meaning
//   ST_IDLE    | no grant held, arbitrate from ptr every cycle
//   ST_GRANT   | grant held; on grantReady advance ptr past winner and re-arbitrate
module round_robin_arbiter #(
  parameter int REQUESTERS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  round_robin_arbiter_if.slave       arb
);
  localparam int PW = $clog2(REQUESTERS);
  localparam logic [PW:0]             NREQ = (PW+1)'(REQUESTERS);
  localparam logic [PW-1:0]           LAST = PW'(REQUESTERS - 1);
  localparam logic [REQUESTERS-1:0]   ONE  = REQUESTERS'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]              state;
  logic [PW-1:0]           ptr;
  logic [REQUESTERS-1:0]   grant_q;
  logic                    valid_q;

  logic                    accept;
  logic [PW-1:0]           gidx;
  logic [PW-1:0]           base;
  logic [2*REQUESTERS-1:0] req_dbl;
  logic [REQUESTERS-1:0]   req_rot;
  logic                    found;
  logic [PW-1:0]           off;
  logic [PW:0]             sum;
  logic [PW:0]             sum_wrap;
  logic [PW-1:0]           win;
  logic [REQUESTERS-1:0]   win_oh;

  assign accept = (state == ST_GRANT) && arb.grantReady;

  // On accept the search starts just past the granted index, so the winner
  // of a held grant only becomes eligible again after everyone else ahead of it.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_q[i]) gidx = i[PW-1:0];
    end
    base = ptr;
    if (accept) base = (gidx == LAST) ? '0 : gidx + 1'b1;
  end

  // Rotate the request vector so index base sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {arb.request, arb.request};
    req_rot = req_dbl[base +: REQUESTERS];
    found   = 1'b0;
    off     = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = i[PW-1:0];
      end
    end
    sum      = {1'b0, base} + {1'b0, off};
    sum_wrap = sum - NREQ;
    win      = (sum >= NREQ) ? sum_wrap[PW-1:0] : sum[PW-1:0];
    win_oh   = found ? (ONE << win) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state   <= ST_GRANT;
            grant_q <= win_oh;
            valid_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (arb.grantReady) begin
            ptr <= base;
            if (found) begin
              grant_q <= win_oh;
              valid_q <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.grantOneHot = grant_q;
  assign arb.grantValid  = valid_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a circular-search reference model.
module tb_round_robin_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  round_robin_arbiter_if #(.REQUESTERS(N)) arb ();

  round_robin_arbiter #(.REQUESTERS(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (arb)
  );

  always #5 clk = ~clk;

  // Reference model: pointer and granted index (-1 = nothing granted).
  int m_ptr    = 0;
  int m_g      = -1;
  bit model_on = 1'b0;
  int waitcnt [N];
  logic [N-1:0] dut_oh_prev = '0;
  logic         dut_v_prev  = 1'b0;

  function automatic int find_winner(logic [N-1:0] req, int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_index(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge, comparison at the following falling edge.
  initial begin
    for (int i = 0; i < N; i++) waitcnt[i] = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < N; i++) waitcnt[i] = 0;
      end else if (model_on && dut_v_prev && arb.grantReady) begin
        int gi;
        int worst;
        gi = onehot_index(dut_oh_prev);
        worst = 0;
        for (int i = 0; i < N; i++) begin
          if (!arb.request[i] || i == gi) waitcnt[i] = 0;
          else waitcnt[i]++;
          if (waitcnt[i] > worst) worst = waitcnt[i];
        end
        checks++;
        if (worst > N - 1) begin
          errors++;
          $display("FAIL fairness: waited %0d accepts, bound %0d", worst, N - 1);
        end
      end else begin
        for (int i = 0; i < N; i++) if (!arb.request[i]) waitcnt[i] = 0;
      end

      if (!reset_n) begin
        m_ptr    = 0;
        m_g      = -1;
        model_on = 1'b1;
      end else if (m_g < 0) begin
        m_g = find_winner(arb.request, m_ptr);
      end else if (arb.grantReady) begin
        m_ptr = (m_g + 1) % N;
        m_g   = find_winner(arb.request, m_ptr);
      end

      @(negedge clk);
      if (model_on) begin
        logic [N-1:0] exp_oh;
        exp_oh = (m_g < 0) ? '0 : (N'(1) << m_g);
        chk("model_grant", arb.grantOneHot, exp_oh);
        chk("model_valid", N'(arb.grantValid), N'(m_g >= 0));
        checks++;
        if ($countones(arb.grantOneHot) > 1 || arb.grantValid !== (arb.grantOneHot != '0)) begin
          errors++;
          $display("FAIL onehot_valid: grant %h valid %b", arb.grantOneHot, arb.grantValid);
        end
      end
      dut_oh_prev = arb.grantOneHot;
      dut_v_prev  = arb.grantValid;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    arb.request    = '0;
    arb.grantReady = 1'b0;
    step();
    step();
    chk("reset_grant", arb.grantOneHot, 8'h00);
    chk("reset_valid", N'(arb.grantValid), 8'h00);
    reset_n = 1'b1;

    // Grant held while not ready, even after the request drops.
    arb.request = 8'b0000_0100;
    step();
    chk("hold_first", arb.grantOneHot, 8'h04);
    chk("hold_valid", N'(arb.grantValid), 8'h01);
    arb.request = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_after_drop", arb.grantOneHot, 8'h04);
    end
    arb.grantReady = 1'b1;
    step();
    chk("idle_after_accept", arb.grantOneHot, 8'h00);
    arb.grantReady = 1'b0;

    // Full request, constant ready: walk 0..7 and wrap with no bubbles.
    reset_n = 1'b0;
    step();
    reset_n     = 1'b1;
    arb.request = 8'hFF;
    step();
    chk("sweep_0", arb.grantOneHot, 8'h01);
    arb.grantReady = 1'b1;
    for (int k = 1; k <= N; k++) begin
      logic [N-1:0] e;
      e = N'(1) << (k % N);
      step();
      chk("sweep", arb.grantOneHot, e);
    end

    // Wrap-around from index 6 through 7 back to 0.
    arb.request = 8'b0100_0000;
    step();
    chk("wrap_6", arb.grantOneHot, 8'h40);
    arb.request = 8'b1000_0001;
    step();
    chk("wrap_7", arb.grantOneHot, 8'h80);
    step();
    chk("wrap_0", arb.grantOneHot, 8'h01);

    // Accept with nothing pending returns to idle; later request wins one cycle on.
    arb.request = 8'h02;
    step();
    chk("pre_idle", arb.grantOneHot, 8'h02);
    arb.request = 8'h00;
    step();
    chk("to_idle_grant", arb.grantOneHot, 8'h00);
    chk("to_idle_valid", N'(arb.grantValid), 8'h00);
    arb.grantReady = 1'b0;
    step();
    arb.request = 8'h02;
    step();
    chk("idle_regrant", arb.grantOneHot, 8'h02);

    // Reset during a held grant with ready high drops it; restart from ptr 0.
    arb.request    = 8'h10;
    arb.grantReady = 1'b1;
    step();
    chk("pre_reset", arb.grantOneHot, 8'h10);
    reset_n     = 1'b0;
    arb.request = 8'h90;
    step();
    chk("reset_drop", arb.grantOneHot, 8'h00);
    reset_n        = 1'b1;
    arb.grantReady = 1'b0;
    step();
    chk("post_reset_first", arb.grantOneHot, 8'h10);

    // Randomized traffic with sticky requests so fairness is exercised.
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] flip;
      flip = N'($urandom) & N'($urandom) & N'($urandom);
      arb.request    = arb.request ^ flip;
      arb.grantReady = ($urandom_range(0, 2) != 0);
      reset_n        = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
